neuron_scheduler: RTL and testbench

Time-multiplexed controller that advances N Izhikevich neurons by one simulation step per `start` request, sharing a single combinational v/u update datapath between them. It holds every neuron's v and u state in a register bank and fetches each neuron's input current through an address/data port. It reports spikes both as per-neuron events and as a per-step spike vector. It sits between the network-level step sequencer and the neuron arithmetic.

---
 rtl/neuron_scheduler_pkg.sv | 26 ++
 rtl/neuron_scheduler_if.sv | 36 +++
 rtl/neuron_scheduler_izh_update_core.sv | 33 +++
 rtl/neuron_scheduler.sv | 121 ++++++++++++
 tb/tb_neuron_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_scheduler_pkg.sv
// Shared types and constants for the Izhikevich neuron scheduler.
// Holds the FSM state enum, datapath constants and state/current types.
package neuron_pkg;

    typedef logic signed [31:0] state_t;
    typedef logic signed [10:0] cur_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } sched_state_e;

    localparam state_t IZH_BIAS = 32'sd1400;
    localparam int     SH_SQ    = 8;
    localparam int     SH_V     = 2;
    localparam int     SH_U     = 6;

    localparam state_t DEF_THRESHOLD = 32'sd300;
    localparam state_t DEF_C         = -32'sd650;
    localparam state_t DEF_D         = 32'sd80;
    localparam state_t DEF_U_INIT    = -32'sd163;

endpackage

// File: rtl/neuron_scheduler_if.sv
// Bus bundle between the step sequencer (master) and the scheduler (slave).
// Carries start/busy/done, current fetch, spike reports and state config/readback.
interface neuron_scheduler_if #(
    parameter int N_NEURONS = 8,
    parameter int AW        = $clog2(N_NEURONS)
);
    import neuron_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        cur_addr;
    cur_t                 cur_I;
    logic                 spike_valid;
    logic [AW-1:0]        spike_id;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    state_t               cfg_v;
    state_t               cfg_u;
    state_t               rd_v;
    state_t               rd_u;

    modport master (
        output start, cur_I, cfg_we, cfg_addr, cfg_v, cfg_u,
        input  busy, done, cur_addr, spike_valid, spike_id,
        input  spike_vec, rd_v, rd_u
    );

    modport slave (
        input  start, cur_I, cfg_we, cfg_addr, cfg_v, cfg_u,
        output busy, done, cur_addr, spike_valid, spike_id,
        output spike_vec, rd_v, rd_u
    );

endinterface

// File: rtl/neuron_scheduler_izh_update_core.sv
// Combinational Izhikevich v/u update for one neuron; 32-bit wrapping math.
// Ports: v, u, i_cur in; v_next, u_next, spike out.
module izh_update_core
    import neuron_pkg::*;
#(
    parameter state_t THRESHOLD = DEF_THRESHOLD,
    parameter state_t C         = DEF_C,
    parameter state_t D         = DEF_D
) (
    input  state_t v,
    input  state_t u,
    input  cur_t   i_cur,
    output state_t v_next,
    output state_t u_next,
    output logic   spike
);

    state_t sq;
    state_t iv;
    state_t un;

    always_comb begin
        sq = v * v;
        iv = (sq >>> SH_SQ) + (v <<< 1) + (v <<< 2)
           + IZH_BIAS - u + state_t'(i_cur);
        // recovery update uses the old v, not iv
        un = u + (((v >>> SH_V) - u) >>> SH_U);
        spike  = (iv > THRESHOLD);
        v_next = spike ? C : iv;
        u_next = spike ? (un + D) : un;
    end

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexed scheduler stepping N Izhikevich neurons through one datapath.
// Ports: clk, rst (sync, active-high), bus (slave side of neuron_scheduler_if).
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int     N_NEURONS = 8,
    parameter int     AW        = $clog2(N_NEURONS),
    parameter state_t THRESHOLD = DEF_THRESHOLD,
    parameter state_t C         = DEF_C,
    parameter state_t D         = DEF_D,
    parameter state_t U_INIT    = DEF_U_INIT
) (
    input logic               clk,
    input logic               rst,
    neuron_scheduler_if.slave bus
);

    sched_state_e state, state_n;

    logic [AW-1:0]        k;
    state_t               v_mem [N_NEURONS];
    state_t               u_mem [N_NEURONS];
    state_t               op_v, op_u;
    cur_t                 op_i;
    state_t               res_v, res_u;
    logic                 res_spk;
    logic [N_NEURONS-1:0] spike_vec;

    state_t               nv, nu;
    logic                 nspk;
    logic                 last_k;

    assign last_k = (k == AW'(N_NEURONS - 1));

    izh_update_core #(
        .THRESHOLD (THRESHOLD),
        .C         (C),
        .D         (D)
    ) u_core (
        .v      (op_v),
        .u      (op_u),
        .i_cur  (op_i),
        .v_next (nv),
        .u_next (nu),
        .spike  (nspk)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (bus.start) state_n = S_FETCH;
            S_FETCH:   state_n = S_COMPUTE;
            S_COMPUTE: state_n = S_WRITE;
            S_WRITE:   state_n = last_k ? S_DONE : S_FETCH;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            op_v      <= '0;
            op_u      <= '0;
            op_i      <= '0;
            res_v     <= '0;
            res_u     <= '0;
            res_spk   <= 1'b0;
            spike_vec <= '0;
            for (int j = 0; j < N_NEURONS; j++) begin
                v_mem[j] <= C;
                u_mem[j] <= U_INIT;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    // start has priority; a same-cycle config write is dropped
                    if (bus.start) begin
                        k         <= '0;
                        spike_vec <= '0;
                    end else if (bus.cfg_we) begin
                        v_mem[bus.cfg_addr] <= bus.cfg_v;
                        u_mem[bus.cfg_addr] <= bus.cfg_u;
                    end
                end
                S_FETCH: begin
                    op_v <= v_mem[k];
                    op_u <= u_mem[k];
                    op_i <= bus.cur_I;
                end
                S_COMPUTE: begin
                    res_v   <= nv;
                    res_u   <= nu;
                    res_spk <= nspk;
                end
                S_WRITE: begin
                    v_mem[k] <= res_v;
                    u_mem[k] <= res_u;
                    if (res_spk) spike_vec[k] <= 1'b1;
                    if (!last_k) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.spike_valid = (state == S_WRITE) && res_spk;
    assign bus.spike_id    = k;
    assign bus.cur_addr    = k;
    assign bus.spike_vec   = spike_vec;
    assign bus.rd_v        = v_mem[bus.cfg_addr];
    assign bus.rd_u        = u_mem[bus.cfg_addr];

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler with N=4 and a step-level model.
// Per-cycle compare of busy/done/spike/cur_addr plus state readback checks.
module tb_neuron_scheduler;
    import neuron_pkg::*;

    localparam int N  = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_scheduler_if #(.N_NEURONS(N), .AW(AW)) bus ();

    neuron_scheduler #(.N_NEURONS(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cur_t cur_tab [N];
    assign bus.cur_I = cur_tab[bus.cur_addr];

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;
    int e0       = -100;
    int elast    = -100;
    bit exp_spk [N];
    int mv [N];
    int mu [N];
    logic [N-1:0] mvec;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // cycle-level expectations derived from the step start edge e0
    always @(negedge clk) begin
        int r;
        bit eb, ed, es;
        int ek;
        r  = ecount - e0;
        eb = (ecount >= e0) && (ecount <= elast);
        ed = eb && (r == 3 * N);
        es = 1'b0;
        ek = 0;
        if (eb && r >= 2 && r < 3 * N && ((r - 2) % 3) == 0) begin
            ek = (r - 2) / 3;
            es = exp_spk[ek];
        end
        chk("busy", bus.busy, eb);
        chk("done", bus.done, ed);
        chk("spike_valid", bus.spike_valid, es);
        if (es) chk("spike_id", bus.spike_id, ek);
        if (eb && r < 3 * N && (r % 3) == 0)
            chk("cur_addr", bus.cur_addr, r / 3);
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = -650;
            mu[i] = -163;
            exp_spk[i] = 1'b0;
        end
        mvec = '0;
    endtask

    task automatic model_step();
        mvec = '0;
        for (int i = 0; i < N; i++) begin
            int v, u, iv, un;
            v  = mv[i];
            u  = mu[i];
            iv = fdiv(v * v, 256) + 6 * v + 1400 - u + int'(cur_tab[i]);
            un = u + fdiv(fdiv(v, 4) - u, 64);
            if (iv > 300) begin
                mv[i] = -650;
                mu[i] = un + 80;
                exp_spk[i] = 1'b1;
                mvec[i] = 1'b1;
            end else begin
                mv[i] = iv;
                mu[i] = un;
                exp_spk[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        elast = ecount;
        wait_cycles(1);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_step(bit with_cfg);
        model_step();
        e0    = ecount + 1;
        elast = e0 + 3 * N;
        bus.start = 1'b1;
        if (with_cfg) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 2'd3;
            bus.cfg_v    = 1234;
            bus.cfg_u    = 77;
        end
        wait_cycles(1);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic full_step(bit with_cfg);
        start_step(with_cfg);
        wait_cycles(3 * N + 1);
    endtask

    task automatic cfg_write(int a, int v, int u);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_v    = v;
        bus.cfg_u    = u;
        wait_cycles(1);
        bus.cfg_we = 1'b0;
        mv[a] = v;
        mu[a] = u;
        #1;
        chk("cfg_readback_v", bus.rd_v, v);
    endtask

    task automatic rd_at(int a, output longint v, output longint u);
        bus.cfg_addr = AW'(a);
        #1;
        v = bus.rd_v;
        u = bus.rd_u;
    endtask

    task automatic check_all();
        longint v, u;
        for (int i = 0; i < N; i++) begin
            rd_at(i, v, u);
            chk($sformatf("v[%0d]", i), v, mv[i]);
            chk($sformatf("u[%0d]", i), u, mu[i]);
        end
        chk("spike_vec", bus.spike_vec, mvec);
    endtask

    initial begin
        longint v, u;
        bus.start    = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_v    = '0;
        bus.cfg_u    = '0;
        for (int i = 0; i < N; i++) cur_tab[i] = '0;
        model_reset();

        rst = 1'b1;
        wait_cycles(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_spike_valid", bus.spike_valid, 0);
        chk("rst_cur_addr", bus.cur_addr, 0);
        chk("rst_spike_id", bus.spike_id, 0);
        chk("rst_spike_vec", bus.spike_vec, 0);
        rst = 1'b0;
        wait_cycles(1);
        check_all();

        // quiescent step from reset state
        full_step(1'b0);
        check_all();
        for (int i = 0; i < N; i++) begin
            rd_at(i, v, u);
            chk("lit_quiet_v", v, -687);
            chk("lit_quiet_u", u, -163);
        end

        // single configured spiker
        reset_dut();
        cfg_write(2, 200, 0);
        full_step(1'b0);
        check_all();
        rd_at(2, v, u);
        chk("lit_spk_v2", v, -650);
        chk("lit_spk_u2", u, 80);
        chk("lit_spk_vec", bus.spike_vec, 4'b0100);

        // threshold edge: iv=300 holds, iv=301 fires
        reset_dut();
        cfg_write(0, 0, 1100);
        cfg_write(1, 0, 1099);
        full_step(1'b0);
        check_all();
        rd_at(0, v, u);
        chk("lit_thr_v0", v, 300);
        rd_at(1, v, u);
        chk("lit_thr_v1", v, -650);

        // start/cfg_we while busy, and start+cfg_we together in IDLE
        start_step(1'b0);
        wait_cycles(4);
        bus.start    = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_v    = 999;
        bus.cfg_u    = 999;
        wait_cycles(1);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        wait_cycles(3 * N + 1 - 5);
        check_all();
        full_step(1'b1);
        check_all();

        // reset in the middle of a step
        start_step(1'b0);
        wait_cycles(4);
        reset_dut();
        chk("midrst_busy", bus.busy, 0);
        check_all();
        chk("lit_midrst_vec", bus.spike_vec, 0);
        wait_cycles(3 * N);

        // per-neuron currents at the extremes
        cur_tab[0] = -11'sd1024;
        cur_tab[1] = 11'sd1023;
        full_step(1'b0);
        check_all();
        rd_at(0, v, u);
        chk("lit_cur_v0", v, -1711);
        chk("lit_cur_spk1", bus.spike_vec[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
